// File: rtl/serdes_pkg.sv
// Shared serializer/deserializer word and frame definitions.
package serdes_pkg;
  localparam int SERDES_WORD_W    = 40;
  localparam int SERDES_FRAME_LEN = 40;

  typedef logic [SERDES_WORD_W-1:0] serdes_word_t;
endpackage

// File: rtl/ser_feed_fifo.sv
// Small word FIFO feeding the serializer launch logic.
module ser_feed_fifo #(
  parameter int WIDTH = 40,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push)
      mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)
        rd_ptr <= rd_ptr + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end
endmodule

// File: rtl/ser_word_feeder.sv
// Buffers producer words and launches one per serial frame,
// spacing data_rdy strobes at least FRAME_LEN cycles apart.
module ser_word_feeder
  import serdes_pkg::*;
#(
  parameter int WIDTH     = SERDES_WORD_W,
  parameter int DEPTH     = 4,
  parameter int FRAME_LEN = SERDES_FRAME_LEN
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [WIDTH-1:0]       in_data,
  output logic                   in_ready,
  output logic                   data_rdy,
  output logic [WIDTH-1:0]       data_out,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic                   busy,
  output logic                   overflow
);
  localparam int GW = $clog2(FRAME_LEN);

  logic [GW-1:0]    gap;
  logic [WIDTH-1:0] head;
  logic             full;
  logic             empty;
  logic             push;
  logic             launch;

  assign in_ready = !full;
  assign push     = in_valid && in_ready;
  // Launch sees the pre-edge level, so a word pushed now waits one edge.
  assign launch   = (gap == '0) && !empty;
  assign busy     = (gap != '0);

  ser_feed_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (launch),
    .wdata (in_data),
    .head  (head),
    .level (fifo_level),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gap <= '0;
    end else if (launch) begin
      gap <= GW'(FRAME_LEN - 1);
    end else if (gap != '0) begin
      gap <= gap - GW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_rdy <= 1'b0;
      data_out <= '0;
    end else begin
      data_rdy <= launch;
      if (launch)
        data_out <= head;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      overflow <= 1'b0;
    else if (in_valid && !in_ready)
      overflow <= 1'b1;
  end
endmodule

// File: tb/tb_ser_word_feeder.sv
// Scoreboard bench for ser_word_feeder: directed pushes, monitor-checked launches.
module tb_ser_word_feeder;
  localparam int W  = 40;
  localparam int D  = 4;
  localparam int FL = 40;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [W-1:0]  in_data;
  logic          in_ready;
  logic          data_rdy;
  logic [W-1:0]  data_out;
  logic [2:0]    fifo_level;
  logic          busy;
  logic          overflow;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  logic [W-1:0] sb [$];
  int           launch_t [$];
  logic [W-1:0] exp_w;
  int           last_t;
  bit           have_last = 0;

  ser_word_feeder #(
    .WIDTH     (W),
    .DEPTH     (D),
    .FRAME_LEN (FL)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .data_rdy   (data_rdy),
    .data_out   (data_out),
    .fifo_level (fifo_level),
    .busy       (busy),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Monitor: every strobe pops the scoreboard and checks spacing.
  always @(negedge clk) begin
    if (rst) begin
      have_last = 0;
    end else if (data_rdy) begin
      launch_t.push_back(cyc);
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_launch: got %h, want none", data_out);
      end else begin
        exp_w = sb.pop_front();
        if (data_out !== exp_w) begin
          n_bad++;
          $display("FAIL launch_data: got %h, want %h", data_out, exp_w);
        end
      end
      if (have_last) begin
        n_cmp++;
        if (cyc - last_t < FL) begin
          n_bad++;
          $display("FAIL launch_spacing: got %0d, want >= %0d",
                   cyc - last_t, FL);
        end
      end
      last_t    = cyc;
      have_last = 1;
    end
  end

  task automatic wait_drain(input string name);
    int n = 0;
    while (n < 600 && !(sb.size() == 0 && !busy &&
           fifo_level == 0 && !data_rdy)) begin
      @(negedge clk);
      n++;
    end
    chk(name, 64'(n < 600), 64'd1);
  endtask

  task automatic send(input logic [W-1:0] d, input bit expect_it);
    in_valid = 1'b1;
    in_data  = d;
    if (expect_it) sb.push_back(d);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int nb;
    int nr;
    int n;

    // Reset with random inputs
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (4) begin
      @(negedge clk);
      in_valid = 1'($urandom_range(0, 1));
      in_data  = W'({$urandom(), $urandom()});
    end
    #1;
    chk("rst_data_rdy", 64'(data_rdy), 64'd0);
    chk("rst_data_out", 64'(data_out), 64'd0);
    chk("rst_level", 64'(fifo_level), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    rst      = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_rdy", 64'(data_rdy), 64'd0);
    chk("idle_busy", 64'(busy), 64'd0);

    // Single word
    launch_t.delete();
    send(40'hA5A5_5A5A_01, 1);
    k = cyc;
    chk("single_level", 64'(fifo_level), 64'd1);
    chk("single_rdy_early", 64'(data_rdy), 64'd0);
    nb = 0;
    nr = 0;
    repeat (45) begin
      @(negedge clk);
      nb += int'(busy);
      nr += int'(data_rdy);
    end
    chk("single_busy_cycles", 64'(nb), 64'd39);
    chk("single_pulses", 64'(nr), 64'd1);
    chk("single_latency",
        64'(launch_t.size() > 0 ? launch_t[0] - k : -1), 64'd1);
    chk("single_level_end", 64'(fifo_level), 64'd0);

    // Burst of three
    wait_drain("drain_single");
    launch_t.delete();
    send(40'd1, 1);
    k = cyc;
    send(40'd2, 1);
    send(40'd3, 1);
    wait_drain("drain_burst");
    chk("burst_count", 64'(launch_t.size()), 64'd3);
    if (launch_t.size() >= 3) begin
      chk("burst_first", 64'(launch_t[0] - k), 64'd1);
      chk("burst_gap1", 64'(launch_t[1] - launch_t[0]), 64'd40);
      chk("burst_gap2", 64'(launch_t[2] - launch_t[1]), 64'd40);
    end

    // Full and overflow during a busy window
    send(40'hC0_0000_0000, 1);
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      in_data  = 40'hF0_0000_0000 + W'(i);
      if (i < 4) sb.push_back(in_data);
      @(negedge clk);
      if (i == 3) begin
        chk("full_level", 64'(fifo_level), 64'd4);
        chk("full_in_ready", 64'(in_ready), 64'd0);
        chk("full_no_ovf_yet", 64'(overflow), 64'd0);
      end
      if (i == 4) chk("ovf_set", 64'(overflow), 64'd1);
    end
    in_valid = 1'b0;
    chk("full_level_hold", 64'(fifo_level), 64'd4);
    wait_drain("drain_full");
    chk("ovf_sticky", 64'(overflow), 64'd1);
    chk("drained_in_ready", 64'(in_ready), 64'd1);

    // Simultaneous push/pop at a launch edge with a full FIFO
    send(40'h5A_5A5A_5A00, 1);
    @(negedge clk);
    for (int i = 1; i <= 4; i++)
      send(40'h3C_0000_0000 + W'(i), 1);
    chk("sim_level_full", 64'(fifo_level), 64'd4);
    n = 0;
    while (busy && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("sim_idle_reached", 64'(busy), 64'd0);
    in_valid = 1'b1;
    in_data  = 40'h3C_0000_0005;
    @(negedge clk);
    chk("sim_level_pop", 64'(fifo_level), 64'd3);
    chk("sim_launch", 64'(data_rdy), 64'd1);
    chk("sim_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    sb.push_back(40'h3C_0000_0005);
    in_valid = 1'b0;
    chk("sim_level_push", 64'(fifo_level), 64'd4);
    wait_drain("drain_sim");

    // Reset mid-frame with two words buffered
    send(40'h77_0000_0001, 1);
    send(40'h77_0000_0002, 0);
    send(40'h77_0000_0003, 0);
    chk("mid_level", 64'(fifo_level), 64'd2);
    repeat (8) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_rdy", 64'(data_rdy), 64'd0);
    chk("mid_rst_data", 64'(data_out), 64'd0);
    chk("mid_rst_level", 64'(fifo_level), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_ovf", 64'(overflow), 64'd0);
    chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    launch_t.delete();
    repeat (60) @(negedge clk);
    chk("post_rst_no_launch", 64'(launch_t.size()), 64'd0);
    send(40'h99_8877_6655, 1);
    wait_drain("drain_post_rst");
    chk("post_rst_one_launch", 64'(launch_t.size()), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ser_word_feeder.md
Name: ser_word_feeder

Overview:
- Upstream stage of the serializer. Buffers 40-bit words from a valid/ready producer in a small FIFO.
- Launches one word per serial frame to the serializer as a one-cycle data_rdy pulse with data_out.
- Launches are spaced at least FRAME_LEN cycles apart, so a frame in flight is never truncated by a new load.

Parameters:
- WIDTH, 40, word width; must match the serializer input.
- DEPTH, 4, FIFO depth in words; power of 2, at least 2.
- FRAME_LEN, 40, minimum cycles between successive data_rdy pulses; must be at least 2.

Ports:
- clk  input  1  clock; all state on posedge.
- rst  input  1  reset; asynchronous, active-high.
- in_valid  input  1  producer offers in_data this cycle.
- in_data  input  WIDTH  producer word.
- in_ready  output  1  FIFO not full; push occurs when in_valid && in_ready at posedge.
- data_rdy  output  1  one-cycle load strobe to the serializer.
- data_out  output  WIDTH  word to the serializer; valid while data_rdy=1, held otherwise.
- fifo_level  output  $clog2(DEPTH)+1  words currently buffered.
- busy  output  1  frame spacing window active (gap counter non-zero).
- overflow  output  1  sticky flag: set when in_valid=1 while in_ready=0.

Behaviour:
- Reset (asynchronous, active-high), output values:
  - data_rdy=0, data_out=0, fifo_level=0, busy=0, overflow=0, in_ready=1.
  - FIFO pointers and the gap counter are cleared.
  - Reset asserted mid-frame aborts immediately. Buffered words are discarded; none are launched.
- Gap counter gap, range 0..FRAME_LEN-1, reset 0:
  - Launch condition: launch = (gap==0) && (fifo_level>0).
  - On a launch edge: gap <= FRAME_LEN-1.
  - Otherwise: decrement if gap>0.
  - Result: consecutive launches are exactly FRAME_LEN cycles apart while the FIFO is non-empty.
- Output registers:
  - data_rdy <= launch. It is never high for two consecutive cycles.
  - On launch, data_out <= FIFO head and the head is popped. Otherwise data_out holds its value.
- busy = (gap != 0). It is high for FRAME_LEN-1 cycles after each launch edge.
- Latency: a word pushed into an empty, idle block at edge k launches at edge k+1, so data_rdy is high in the cycle after edge k+1.
- in_ready = (fifo_level < DEPTH). It is computed combinationally from the current level and does not anticipate a same-cycle pop.
- Push when full is refused: the word is dropped, overflow is set, and fifo_level is unchanged. overflow stays set until rst.
- Simultaneous push and pop: both occur; fifo_level is unchanged; FIFO order is preserved.
- Push into an empty FIFO while gap==0: the word is not launched at that same edge, because launch is evaluated on the pre-edge level. It launches at the next edge.
- FIFO pointers wrap modulo DEPTH. fifo_level never exceeds DEPTH and never underflows, because pop only occurs when level>0.
- No state machine beyond the gap counter and the FIFO. The two conditions are idle (gap==0) and spacing (gap>0).

Decomposition:
- Shared package serdes_pkg:
  - SERDES_WORD_W=40 and SERDES_FRAME_LEN=40.
  - typedef logic [SERDES_WORD_W-1:0] serdes_word_t.
  - Reused by the serializer and deserializer.
- One sub-module, ser_feed_fifo:
  - Synchronous-write, registered-level FIFO with push, pop, head, level, full and empty.
  - Async active-high reset on clk.
- Gap counter, launch logic and overflow flag live in the top.

Test Plan:
- Reset: hold rst with random inputs -> data_rdy=0, data_out=0, fifo_level=0, busy=0, overflow=0, in_ready=1; release -> idle.
- Single word: push 40'hA5A5_5A5A_01 at edge k -> data_rdy=1 for exactly one cycle after edge k+1, data_out=40'hA5A5_5A5A_01, busy high 39 cycles, fifo_level back to 0.
- Burst of 3: push words 1,2,3 on consecutive cycles -> data_rdy pulses at edges k+1, k+41, k+81 with data_out 1,2,3 in order.
- Full and overflow (DEPTH=4): push 6 words back-to-back during a busy window -> in_ready=0 once level=4, 5th/6th words dropped, overflow=1 and sticky; only the 4 accepted words are launched.
- Simultaneous push/pop: level=4 at a launch edge with in_valid=1 -> the push is refused (in_ready was 0) and level goes to 3. Next cycle push with level=3 -> level=4; FIFO order is verified.
- Reset mid-operation: assert rst 10 cycles into a frame with level=2 -> outputs clear immediately; after release no data_rdy until a new push.
